// File: rtl/player_input_ctrl_if.sv
// Key/frame inputs and motion/pause outputs of the player input stage.
// The board/test side uses the master modport; player_input_ctrl uses slave.
interface player_input_ctrl_if;
   logic keyLeftN;
   logic keyRightN;
   logic keyPauseN;
   logic startOfFrame;
   logic moveLeft;
   logic moveRight;
   logic pause;

   modport master (
      output keyLeftN, keyRightN, keyPauseN, startOfFrame,
      input  moveLeft, moveRight, pause
   );

   modport slave (
      input  keyLeftN, keyRightN, keyPauseN, startOfFrame,
      output moveLeft, moveRight, pause
   );
endinterface

// File: rtl/player_input_ctrl.sv
// Player input stage: synchronizes and debounces the raw keys, arbitrates left/right, and runs the pause FSM.
// Define PLAYER_PAUSE_FRAME_SYNC_EN to defer pause toggles to the next startOfFrame.
module player_input_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input logic           clk,
   input logic           resetN,
   player_input_ctrl_if.slave io
);

   localparam int CNT_W      = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int NKEYS      = 3;
   localparam int KEY_LEFT   = 0;
   localparam int KEY_RIGHT  = 1;
   localparam int KEY_PAUSE  = 2;
   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      RUN    = 1'b0,
      PAUSED = 1'b1
   } pause_state_t;

   logic [NKEYS-1:0] raw_n;
   logic [NKEYS-1:0] sync1_n;
   logic [NKEYS-1:0] sync2_n;
   logic [NKEYS-1:0] stable_n;
   logic [CNT_W-1:0] cnt [NKEYS];

   pause_state_t state;
   logic         pause_prev_n;
   logic         press_edge;
   logic         left_pressed;
   logic         right_pressed;
   logic         move_left_q;
   logic         move_right_q;

   assign raw_n = {io.keyPauseN, io.keyRightN, io.keyLeftN};

   // Two-flop synchronizer; idle level is 1 (released) so reset never looks like a press.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         sync1_n <= '1;
         sync2_n <= '1;
      end else begin
         // NOTE: non-blocking so sync2 takes sync1's previous value, giving two real flop stages.
         sync1_n <= raw_n;
         sync2_n <= sync1_n;
      end
   end

   // Debounce: a new level must persist DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         stable_n <= '1;
         // NOTE: the counter array is small state that must restart clean, so it is reset, unlike a RAM.
         for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NKEYS; i++) begin
            if (sync2_n[i] == stable_n[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == TERM_CNT) begin
               stable_n[i] <= sync2_n[i];
               cnt[i]      <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign press_edge    = pause_prev_n & ~stable_n[KEY_PAUSE];
   assign left_pressed  = ~stable_n[KEY_LEFT];
   assign right_pressed = ~stable_n[KEY_RIGHT];

`ifdef PLAYER_PAUSE_FRAME_SYNC_EN
   logic pending;

   // Pause FSM: a press arms pending; the flip lands on the next frame boundary.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= RUN;
         pause_prev_n <= 1'b1;
         pending      <= 1'b0;
      end else begin
         pause_prev_n <= stable_n[KEY_PAUSE];
         if (io.startOfFrame && pending) begin
            state   <= (state == RUN) ? PAUSED : RUN;
            pending <= 1'b0;
         end else if (press_edge) begin
            pending <= 1'b1;
         end
      end
   end
`else
   logic unused_start_of_frame;
   assign unused_start_of_frame = io.startOfFrame;

   // Pause FSM: flips one cycle after the debounced press edge.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= RUN;
         pause_prev_n <= 1'b1;
      end else begin
         pause_prev_n <= stable_n[KEY_PAUSE];
         if (press_edge) state <= (state == RUN) ? PAUSED : RUN;
      end
   end
`endif

   // Motion only when running and exactly one direction is held, so both outputs are never low together.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         move_left_q  <= 1'b1;
         move_right_q <= 1'b1;
      end else begin
         move_left_q  <= ~(left_pressed  & ~right_pressed & (state == RUN));
         move_right_q <= ~(right_pressed & ~left_pressed  & (state == RUN));
      end
   end

   assign io.moveLeft  = move_left_q;
   assign io.moveRight = move_right_q;
   assign io.pause     = (state == PAUSED);

endmodule
